// File: rtl/fsm_lock_pkg.sv
// rtl/fsm_lock_pkg.sv - shared state encoding, digit width and counter width helper for the lock supervisor
package fsm_lock_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    REPLAY   = 3'd2,
    WAIT_RES = 3'd3,
    UNLOCKED = 3'd4,
    LOCKOUT  = 3'd5
  } state_t;

  localparam int DIGIT_W = 4;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lock_tick_timer.sv
// rtl/lock_tick_timer.sv - loadable down-counter stepped by the clock-enable tick, with a done pulse
module lock_tick_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         i_Rst,
  input  logic         i_ce,
  input  logic         i_load,
  input  logic [W-1:0] iv_load_val,
  output logic         o_done
);

  logic [W-1:0] cnt_q, cnt_d;

  // Done fires in the cycle the count steps 1->0; a load always wins over a tick.
  always_comb begin
    cnt_d  = cnt_q;
    o_done = 1'b0;
    if (i_ce && (cnt_q == W'(1))) o_done = 1'b1;
    if (i_load) cnt_d = iv_load_val;
    else if (i_ce && (cnt_q != '0)) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (i_Rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fsm_lock_supervisor.sv
// rtl/fsm_lock_supervisor.sv - buffers a keyed code, replays it to the checker, tracks failures and lockout
// Optional LOCK_ESCALATE_EN: each consecutive lockout doubles in length, saturating at 8x.
module fsm_lock_supervisor
  import fsm_lock_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int MAX_FAILS    = 3,
  parameter int LOCK_TICKS   = 20,
  parameter int RESP_TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               i_Rst,
  input  logic               i_CE,
  input  logic               i_key_valid,
  input  logic [DIGIT_W-1:0] iv_key,
  input  logic               i_clear,
  input  logic               i_chk_pass,
  input  logic               i_chk_fail,
  output logic               o_key_ready,
  output logic               o_chk_set,
  output logic [DIGIT_W-1:0] ov_chk_data,
  output logic               o_unlocked,
  output logic               o_locked_out,
  output logic [2:0]         ov_fail_cnt,
  output logic [2:0]         ov_state
);

  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int TMAX = (LOCK_TICKS > RESP_TIMEOUT) ? LOCK_TICKS : RESP_TIMEOUT;
`ifdef LOCK_ESCALATE_EN
  localparam int TW = cnt_width(TMAX) + 3;
`else
  localparam int TW = cnt_width(TMAX);
`endif
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam logic [2:0]    MAX_F    = 3'(MAX_FAILS);

  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [DIGIT_W-1:0] dig_buf_q [DIGITS];
  logic [DIGIT_W-1:0] dig_buf_d [DIGITS];
  logic [2:0]         fail_q, fail_d, fail_inc;
  logic [DIGIT_W-1:0] chk_data_q, chk_data_d;
  logic               key_ready_q, key_ready_d;
  logic               unlocked_q, unlocked_d;
  logic               locked_out_q, locked_out_d;
  logic               key_acc, chk_set;
  logic               tmr_load, tmr_done;
  logic [TW-1:0]      tmr_val, lock_len;

  lock_tick_timer #(.W(TW)) u_timer (
    .clk         (clk),
    .i_Rst       (i_Rst),
    .i_ce        (i_CE),
    .i_load      (tmr_load),
    .iv_load_val (tmr_val),
    .o_done      (tmr_done)
  );

`ifdef LOCK_ESCALATE_EN
  logic [1:0] esc_q, esc_d;

  // Level steps on each lockout entry and only a pass (or reset) brings it back down.
  always_comb begin
    esc_d = esc_q;
    if (state_d == UNLOCKED && state_q != UNLOCKED) esc_d = 2'd0;
    else if (state_d == LOCKOUT && state_q != LOCKOUT && esc_q != 2'd3) esc_d = esc_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (i_Rst) esc_q <= 2'd0;
    else       esc_q <= esc_d;
  end

  assign lock_len = TW'(LOCK_TICKS) << esc_q;
`else
  assign lock_len = TW'(LOCK_TICKS);
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    dig_buf_d = dig_buf_q;
    fail_d    = fail_q;
    fail_inc  = (fail_q == MAX_F) ? fail_q : fail_q + 3'd1;
    key_acc   = i_key_valid && key_ready_q;
    chk_set   = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;

    case (state_q)
      IDLE: begin
        if (key_acc) begin
          dig_buf_d[0] = iv_key;
          if (DIGITS == 1) begin
            idx_d   = '0;
            state_d = REPLAY;
          end else begin
            idx_d   = IW'(1);
            state_d = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (i_clear) begin
          for (int i = 0; i < DIGITS; i++) dig_buf_d[i] = '0;
          idx_d   = '0;
          state_d = IDLE;
        end else if (key_acc) begin
          dig_buf_d[idx_q] = iv_key;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = REPLAY;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      REPLAY: begin
        // Reset gates the strobe so an aborted replay never leaks one more digit.
        if (i_CE && !i_Rst) begin
          chk_set = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d    = '0;
            state_d  = WAIT_RES;
            tmr_load = 1'b1;
            tmr_val  = TW'(RESP_TIMEOUT);
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      WAIT_RES: begin
        if (i_chk_fail || tmr_done) begin
          fail_d = fail_inc;
          if (fail_inc == MAX_F) begin
            state_d  = LOCKOUT;
            tmr_load = 1'b1;
            tmr_val  = lock_len;
          end else begin
            state_d = IDLE;
          end
        end else if (i_chk_pass) begin
          fail_d  = 3'd0;
          state_d = UNLOCKED;
        end
      end
      UNLOCKED: begin
        if (i_clear) state_d = IDLE;
      end
      LOCKOUT: begin
        if (tmr_done) begin
          fail_d  = 3'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    chk_data_d   = chk_set ? dig_buf_q[idx_q] : chk_data_q;
    key_ready_d  = (state_d == IDLE) || (state_d == COLLECT);
    unlocked_d   = (state_d == UNLOCKED);
    locked_out_d = (state_d == LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (i_Rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      fail_q       <= 3'd0;
      chk_data_q   <= '0;
      key_ready_q  <= 1'b0;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
      for (int i = 0; i < DIGITS; i++) dig_buf_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      fail_q       <= fail_d;
      chk_data_q   <= chk_data_d;
      key_ready_q  <= key_ready_d;
      unlocked_q   <= unlocked_d;
      locked_out_q <= locked_out_d;
      dig_buf_q    <= dig_buf_d;
    end
  end

  assign o_key_ready  = key_ready_q;
  assign o_chk_set    = chk_set;
  assign ov_chk_data  = chk_data_d;
  assign o_unlocked   = unlocked_q;
  assign o_locked_out = locked_out_q;
  assign ov_fail_cnt  = fail_q;
  assign ov_state     = state_q;

endmodule

// File: tb/tb_fsm_lock_supervisor.sv
// tb/tb_fsm_lock_supervisor.sv - self-checking bench for fsm_lock_supervisor (honours LOCK_ESCALATE_EN)
module tb_fsm_lock_supervisor;

  localparam int DIGITS       = 4;
  localparam int MAX_FAILS    = 3;
  localparam int LOCK_TICKS   = 4;
  localparam int RESP_TIMEOUT = 3;

  logic       clk = 1'b0;
  logic       i_Rst, i_CE, i_key_valid, i_clear, i_chk_pass, i_chk_fail;
  logic [3:0] iv_key;
  logic       o_key_ready, o_chk_set, o_unlocked, o_locked_out;
  logic [3:0] ov_chk_data;
  logic [2:0] ov_fail_cnt, ov_state;

  int         checks = 0;
  int         failures = 0;
  int         ce_div = 0;
  logic [3:0] got_q [$];
  logic [3:0] code [DIGITS];
  int         ce_viol = 0;
  int         lock_ticks = 0;
  int         wait_ticks = 0;
  int         ready_viol = 0;
  int         m_fails = 0;
`ifdef LOCK_ESCALATE_EN
  int         m_level = 0;
`endif

  fsm_lock_supervisor #(
    .DIGITS       (DIGITS),
    .MAX_FAILS    (MAX_FAILS),
    .LOCK_TICKS   (LOCK_TICKS),
    .RESP_TIMEOUT (RESP_TIMEOUT)
  ) dut (
    .clk          (clk),
    .i_Rst        (i_Rst),
    .i_CE         (i_CE),
    .i_key_valid  (i_key_valid),
    .iv_key       (iv_key),
    .i_clear      (i_clear),
    .i_chk_pass   (i_chk_pass),
    .i_chk_fail   (i_chk_fail),
    .o_key_ready  (o_key_ready),
    .o_chk_set    (o_chk_set),
    .ov_chk_data  (ov_chk_data),
    .o_unlocked   (o_unlocked),
    .o_locked_out (o_locked_out),
    .ov_fail_cnt  (ov_fail_cnt),
    .ov_state     (ov_state)
  );

  always #5 clk = ~clk;

  // Clock-enable: one cycle high in every five.
  initial begin
    i_CE = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      i_CE   = (ce_div == 4);
      ce_div = (ce_div == 4) ? 0 : ce_div + 1;
    end
  end

  always @(negedge clk) begin
    if (o_chk_set) begin
      got_q.push_back(ov_chk_data);
      if (!i_CE) ce_viol++;
    end
    if (o_locked_out && i_CE) lock_ticks++;
    if (ov_state == 3'd3 && i_CE) wait_ticks++;
    if (o_locked_out && o_key_ready) ready_viol++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n;
    n = 0;
    while (ov_state !== s && n < budget) begin
      tick();
      n++;
    end
    chk(tag, ov_state, s);
  endtask

  task automatic enter_code(input bit fixed);
    for (int i = 0; i < DIGITS; i++) begin
      code[i]     = fixed ? 4'(i + 1) : 4'($urandom_range(0, 15));
      i_key_valid = 1'b1;
      iv_key      = code[i];
      i_chk_fail  = 1'($urandom_range(0, 1));
      i_chk_pass  = 1'($urandom_range(0, 1));
      tick();
      i_key_valid = 1'b0;
      i_chk_fail  = 1'b0;
      i_chk_pass  = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic run_lockout();
    int n;
    int exp_len;
    n = 0;
    exp_len = LOCK_TICKS;
`ifdef LOCK_ESCALATE_EN
    exp_len = LOCK_TICKS << m_level;
    if (m_level < 3) m_level++;
`endif
    chk("locked_out_asserted", o_locked_out, 1);
    chk("key_ready_in_lockout", o_key_ready, 0);
    lock_ticks = 0;
    ready_viol = 0;
    while (ov_state === 3'd5 && n < 2000) begin
      i_key_valid = 1'($urandom_range(0, 1));
      iv_key      = 4'($urandom_range(0, 15));
      i_clear     = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    i_key_valid = 1'b0;
    i_clear     = 1'b0;
    chk("lockout_ticks", lock_ticks, exp_len);
    chk("ready_low_through_lockout", ready_viol, 0);
    chk("idle_after_lockout", ov_state, 0);
    chk("fail_cnt_cleared_after_lockout", ov_fail_cnt, 0);
    chk("locked_out_dropped", o_locked_out, 0);
    m_fails = 0;
  endtask

  // kind: 0 pass, 1 fail, 2 no verdict (timeout), 3 pass+fail together
  task automatic run_attempt(input int kind, input bit fixed);
    int n;
    wait_state(3'd0, 400, "idle_before_attempt");
    got_q.delete();
    enter_code(fixed);
    n = 0;
    while (got_q.size() < DIGITS && n < 100) begin
      tick();
      n++;
    end
    chk("replay_count", got_q.size(), DIGITS);
    for (int i = 0; i < DIGITS && i < got_q.size(); i++)
      chk($sformatf("replay_digit%0d", i), got_q[i], code[i]);
    chk("state_wait_res", ov_state, 3);
    wait_ticks = 0;
    if (kind == 2) begin
      n = 0;
      while (ov_state === 3'd3 && n < 100) begin
        tick();
        n++;
      end
      chk("timeout_ticks", wait_ticks, RESP_TIMEOUT);
    end else begin
      repeat ($urandom_range(0, 3)) tick();
      i_chk_pass = (kind == 0 || kind == 3);
      i_chk_fail = (kind == 1 || kind == 3);
      tick();
      i_chk_pass = 1'b0;
      i_chk_fail = 1'b0;
    end
    if (kind == 0) begin
      m_fails = 0;
`ifdef LOCK_ESCALATE_EN
      m_level = 0;
`endif
      chk("unlocked", o_unlocked, 1);
      chk("fail_cnt_after_pass", ov_fail_cnt, 0);
      chk("state_unlocked", ov_state, 4);
      i_key_valid = 1'b1;
      iv_key      = 4'($urandom_range(0, 15));
      tick();
      i_key_valid = 1'b0;
      chk("keys_ignored_unlocked", ov_state, 4);
      i_clear = 1'b1;
      tick();
      i_clear = 1'b0;
      chk("clear_relocks", ov_state, 0);
      chk("unlocked_dropped", o_unlocked, 0);
    end else begin
      m_fails++;
      chk("fail_cnt", ov_fail_cnt, m_fails);
      chk("no_unlock_on_fail", o_unlocked, 0);
      if (m_fails == MAX_FAILS) run_lockout();
      else chk("idle_after_fail", ov_state, 0);
    end
  endtask

  initial begin
    i_Rst       = 1'b1;
    i_key_valid = 1'b0;
    iv_key      = 4'd0;
    i_clear     = 1'b0;
    i_chk_pass  = 1'b0;
    i_chk_fail  = 1'b0;
    repeat (3) tick();
    chk("rst_key_ready", o_key_ready, 0);
    chk("rst_chk_set", o_chk_set, 0);
    chk("rst_chk_data", ov_chk_data, 0);
    chk("rst_unlocked", o_unlocked, 0);
    chk("rst_locked_out", o_locked_out, 0);
    chk("rst_fail_cnt", ov_fail_cnt, 0);
    chk("rst_state", ov_state, 0);
    i_Rst = 1'b0;
    tick();
    chk("key_ready_after_rst", o_key_ready, 1);

    run_attempt(0, 1'b1);
    for (int i = 0; i < MAX_FAILS; i++) run_attempt(1, 1'b0);

    // Abort a partial entry: nothing may be replayed.
    wait_state(3'd0, 400, "idle_before_abort");
    got_q.delete();
    iv_key = 4'd5; i_key_valid = 1'b1; tick();
    iv_key = 4'd6; tick();
    i_key_valid = 1'b0;
    chk("collect_after_two_keys", ov_state, 1);
    iv_key = 4'd7; i_key_valid = 1'b1; i_clear = 1'b1; tick();
    i_key_valid = 1'b0; i_clear = 1'b0;
    chk("clear_to_idle", ov_state, 0);
    repeat (30) tick();
    chk("no_replay_after_clear", got_q.size(), 0);
    run_attempt(0, 1'b1);

    run_attempt(2, 1'b0);
    run_attempt(3, 1'b0);

    // Reset after two replayed digits.
    wait_state(3'd0, 400, "idle_before_reset_test");
    got_q.delete();
    for (int i = 0; i < DIGITS; i++) begin
      iv_key = 4'(i + 7); i_key_valid = 1'b1; tick();
    end
    i_key_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (got_q.size() < 2 && n < 100) begin
        tick();
        n++;
      end
    end
    chk("two_digits_before_reset", got_q.size(), 2);
    i_Rst = 1'b1;
    tick();
    chk("midrst_chk_set", o_chk_set, 0);
    chk("midrst_chk_data", ov_chk_data, 0);
    chk("midrst_key_ready", o_key_ready, 0);
    chk("midrst_unlocked", o_unlocked, 0);
    chk("midrst_locked_out", o_locked_out, 0);
    chk("midrst_fail_cnt", ov_fail_cnt, 0);
    chk("midrst_state", ov_state, 0);
    i_Rst = 1'b0;
    m_fails = 0;
`ifdef LOCK_ESCALATE_EN
    m_level = 0;
`endif
    repeat (30) tick();
    chk("no_strobe_after_reset", got_q.size(), 2);
    chk("idle_after_reset", ov_state, 0);

    // Back-to-back lockouts, a pass, then another lockout.
    for (int i = 0; i < 2 * MAX_FAILS; i++) run_attempt(1, 1'b0);
    run_attempt(0, 1'b0);
    for (int i = 0; i < MAX_FAILS; i++) run_attempt(1, 1'b0);

    for (int i = 0; i < 12; i++) run_attempt($urandom_range(0, 3), 1'b0);

    chk("chk_set_only_with_ce", ce_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fsm_lock_supervisor.md
Name: fsm_lock_supervisor

Overview:
Attempt controller that sequences the digit-password checker. It buffers a full code entered at clk rate and replays it to the checker, one digit per 2 Hz clock-enable tick. It then waits for the pass/fail verdict, counts failed attempts and enforces a timed lockout. It sits between the keypad inputs and the checker inside the lock top level, and shares that top level's divider tick as i_CE.

Parameters:
DIGITS, 4, code length in digits (2..8)
MAX_FAILS, 3, consecutive failures that trigger lockout (1..7)
LOCK_TICKS, 20, lockout length in i_CE ticks (20 = 10 s at 2 Hz)
RESP_TIMEOUT, 8, i_CE ticks to wait for a verdict before counting a failure

Ports:
clk  in  1  system clock (10 MHz)
i_Rst  in  1  reset; synchronous, active-high
i_CE  in  1  one-clk tick from the 2 Hz divider
i_key_valid  in  1  key strobe; accepted when o_key_ready=1
iv_key  in  4  key digit
i_clear  in  1  abort entry / relock
i_chk_pass  in  1  checker verdict: correct (one-clk pulse)
i_chk_fail  in  1  checker verdict: wrong (one-clk pulse)
o_key_ready  out  1  supervisor accepts keys
o_chk_set  out  1  one-clk digit strobe to the checker
ov_chk_data  out  4  digit to the checker, valid with o_chk_set
o_unlocked  out  1  code accepted
o_locked_out  out  1  lockout active
ov_fail_cnt  out  3  consecutive failures so far
ov_state  out  3  state encoding, for debug and status LEDs

Behaviour:
- Reset (sync, highest priority): state IDLE. All outputs 0. Buffer, index, tick counter and fail count cleared. Reset mid-replay drops the attempt and emits no further o_chk_set.
- States: IDLE=0, COLLECT=1, REPLAY=2, WAIT_RES=3, UNLOCKED=4, LOCKOUT=5.
- o_key_ready=1 only in IDLE and COLLECT. Keys arriving while it is 0 are ignored.
- IDLE: an accepted key is stored in buf[0], idx=1, next state COLLECT. If DIGITS=1 is ever allowed, go straight to REPLAY.
- COLLECT: an accepted key is stored in buf[idx], idx++. The key that fills buf[DIGITS-1] moves to REPLAY with idx=0. i_clear: discard the buffer, go to IDLE. i_clear has priority over a key in the same cycle.
- REPLAY: on each i_CE, o_chk_set=1 for exactly that clk and ov_chk_data=buf[idx], then idx++. After the last digit, go to WAIT_RES with the tick counter at 0. ov_chk_data holds its last value between strobes. i_clear is ignored.
- WAIT_RES:
  - i_chk_fail, or the tick counter reaching RESP_TIMEOUT (counted on i_CE): fail_cnt++. If the new fail_cnt equals MAX_FAILS, go to LOCKOUT with the counter loaded to LOCK_TICKS; otherwise go to IDLE.
  - i_chk_pass (without fail): go to UNLOCKED, fail_cnt=0.
  - pass and fail in the same cycle: fail wins.
  - verdicts outside WAIT_RES are ignored.
- UNLOCKED: o_unlocked=1. i_clear goes to IDLE. Keys are ignored.
- LOCKOUT: o_locked_out=1. Counter decrements on i_CE. The transition to IDLE happens in the cycle the counter decrements 1->0, and fail_cnt is cleared then. i_clear is ignored.
- o_unlocked and o_locked_out are registered and decoded from the state. They assert on the first cycle in the state.
- ov_fail_cnt saturates at MAX_FAILS.
- All i_CE-based counting uses only the i_CE pulse. A key and i_CE in the same cycle are independent.

Optional Feature:
Macro LOCK_ESCALATE_EN.
- Defined: each consecutive lockout doubles its length: LOCK_TICKS, then 2x, then 4x, saturating at 8x. A 2-bit escalation level drives this; it clears only on i_chk_pass or reset. The lockout counter is widened by 3 bits.
- Undefined: every lockout is LOCK_TICKS, and no escalation register exists.

Decomposition:
- Shared package fsm_lock_pkg holds:
  - state typedef/localparams (IDLE..LOCKOUT, 3-bit)
  - the DIGIT_W=4 constant
  - a clog2-based width function for the counters
- Natural sub-module: lock_tick_timer. A loadable down-counter on i_CE with a done pulse, reused for both the response timeout and the lockout. The top holds the FSM, digit buffer and fail counter.

Test Plan:
Unless noted, DIGITS=4, MAX_FAILS=3, LOCK_TICKS=4, RESP_TIMEOUT=3, i_CE every 5 clks.
- Keys 1,2,3,4 -> 4 o_chk_set pulses, each coincident with i_CE, carrying 1,2,3,4 in order. Then i_chk_pass -> o_unlocked=1, ov_fail_cnt=0. Then i_clear -> IDLE.
- Three wrong attempts, each ending in i_chk_fail -> ov_fail_cnt 1,2,3. After the third: o_locked_out=1 for exactly 4 i_CE ticks, o_key_ready=0 throughout, keys and i_clear ignored, then IDLE with fail_cnt=0.
- Keys 5,6 then i_clear -> IDLE with no o_chk_set. Next keys 1,2,3,4 replay as 1,2,3,4.
- No verdict after replay -> after 3 i_CE ticks fail_cnt increments and the state returns to IDLE. pass and fail in the same cycle -> counted as a failure.
- i_Rst asserted after 2 replayed digits -> all outputs 0 the next cycle, no further o_chk_set.
- With LOCK_ESCALATE_EN: two back-to-back lockout cycles last 4 then 8 ticks. A subsequent pass resets the next lockout to 4.
